// File: rtl/mem_issue_ctrl.sv
// -----------------------------------------------------------------------------
// mem_issue_ctrl
//   Arbitrates the single memory port between the issue stage and the data-side
//   bus. Tracks in-flight loads/stores, tags each one with its kind in a small
//   in-order queue, throttles further issue through wait_mem_o, and after a
//   pipeline flush drains the responses of killed ops without forwarding them
//   to commit.
//
//   Optional feature: define MEM_CTRL_TIMEOUT_EN to add a watchdog. When a
//   response is outstanding and none arrives for TIMEOUT cycles, the watchdog
//   pulses timeout_err_o and returns the controller to its idle state.
//   Without the macro there is no watchdog and timeout_err_o is tied to 0.
//
// Ports
//   clk_i            core clock
//   reset_i          asynchronous, active-high reset
//   mem_issued_i     issue stage launched one mem op this cycle
//   mem_is_store_i   kind of the op qualified by mem_issued_i (1 = store)
//   data_ok_i        bus returned the response of the oldest in-flight op
//   flush_i          pipeline flush (exception / branch redirect)
//   wait_mem_o       block issue of further mem ops
//   resp_valid_o     live response delivered to commit
//   resp_is_store_o  kind of the op for resp_valid_o
//   outstanding_o    current in-flight count
//   draining_o       high while discarding responses of flushed ops
//   timeout_err_o    watchdog fired (one-cycle pulse)
// -----------------------------------------------------------------------------
module mem_issue_ctrl #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1,
    parameter int TIMEOUT         = 255
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             mem_issued_i,
    input  logic             mem_is_store_i,
    input  logic             data_ok_i,
    input  logic             flush_i,
    output logic             wait_mem_o,
    output logic             resp_valid_o,
    output logic             resp_is_store_o,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             draining_o,
    output logic             timeout_err_o
);

    localparam int PTR_W = $clog2(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q;
    logic [PTR_W-1:0]           wr_ptr_q, rd_ptr_q;
    logic                       resp_valid_q, resp_valid_d;
    logic                       resp_is_store_q, resp_is_store_d;
    logic                       issue_acc, pop_acc;
    logic                       wd_fire;

    // Decoded from registers only, so issue never sees a comb path from the bus.
    assign wait_mem_o = (count_q == CNT_W'(MAX_OUTSTANDING)) | (state_q == DRAIN);

    always_comb begin
        issue_acc = mem_issued_i & ~wait_mem_o & ~flush_i;
        pop_acc   = data_ok_i & (count_q != '0);
        count_d   = count_q + CNT_W'(issue_acc) - CNT_W'(pop_acc);

        state_d = state_q;
        case (state_q)
            IDLE:    if (issue_acc) state_d = BUSY;
            BUSY: begin
                if (count_d == '0)  state_d = IDLE;
                else if (flush_i)   state_d = DRAIN;
            end
            DRAIN:   if (count_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Responses of ops killed by a flush (same cycle or while draining) are swallowed.
        resp_valid_d    = pop_acc & (state_q == BUSY) & ~flush_i;
        resp_is_store_d = resp_valid_d & fifo_q[rd_ptr_q];
    end

`ifdef MEM_CTRL_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       timeout_err_q;

    assign wd_fire       = (count_q != '0) & ~data_ok_i & (wd_q == 8'(TIMEOUT - 1));
    assign timeout_err_o = timeout_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT;
    assign wd_fire            = 1'b0;
    assign timeout_err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q         <= IDLE;
            count_q         <= '0;
            fifo_q          <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_is_store_q <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            wd_q            <= '0;
            timeout_err_q   <= 1'b0;
`endif
        end else if (wd_fire) begin
            // Lost response: abandon everything in flight and start clean.
            state_q         <= IDLE;
            count_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            resp_valid_q    <= 1'b0;
            resp_is_store_q <= 1'b0;
`ifdef MEM_CTRL_TIMEOUT_EN
            wd_q            <= '0;
            timeout_err_q   <= 1'b1;
`endif
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            resp_valid_q    <= resp_valid_d;
            resp_is_store_q <= resp_is_store_d;
            if (issue_acc) begin
                fifo_q[wr_ptr_q] <= mem_is_store_i;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_acc) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
`ifdef MEM_CTRL_TIMEOUT_EN
            timeout_err_q <= 1'b0;
            if ((count_q == '0) || data_ok_i) wd_q <= '0;
            else                              wd_q <= wd_q + 8'd1;
`endif
        end
    end

    assign resp_valid_o    = resp_valid_q;
    assign resp_is_store_o = resp_is_store_q;
    assign outstanding_o   = count_q;
    assign draining_o      = (state_q == DRAIN);

endmodule

// File: tb/tb_mem_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_issue_ctrl
//   Directed, table-driven bench for mem_issue_ctrl (MAX_OUTSTANDING = 2).
//   Each vector holds the inputs for one cycle and the outputs expected just
//   after the following rising edge. Hand-written sequences cover async reset
//   in mid-operation and, when MEM_CTRL_TIMEOUT_EN is defined, the watchdog.
// -----------------------------------------------------------------------------
module tb_mem_issue_ctrl;

    localparam int MAXO  = 2;
    localparam int CNT_W = $clog2(MAXO) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             mem_issued, mem_is_store, data_ok, flush;
    logic             wait_mem, resp_valid, resp_is_store, draining, timeout_err;
    logic [CNT_W-1:0] outstanding;

    int pass_cnt  = 0;
    int total_cnt = 0;

    mem_issue_ctrl #(.MAX_OUTSTANDING(MAXO), .CNT_W(CNT_W), .TIMEOUT(255)) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .mem_issued_i    (mem_issued),
        .mem_is_store_i  (mem_is_store),
        .data_ok_i       (data_ok),
        .flush_i         (flush),
        .wait_mem_o      (wait_mem),
        .resp_valid_o    (resp_valid),
        .resp_is_store_o (resp_is_store),
        .outstanding_o   (outstanding),
        .draining_o      (draining),
        .timeout_err_o   (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic  iss, st, ok, fl;
        logic  wt, rv, rs, dr;
        int    out;
        string name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iss, st, ok, fl, wt, rv, rs, dr, input int out, input string nm);
        vec_t v;
        v.iss = iss; v.st = st; v.ok = ok; v.fl = fl;
        v.wt = wt; v.rv = rv; v.rs = rs; v.dr = dr;
        v.out = out; v.name = nm;
        vq.push_back(v);
    endtask

    // {timeout_err, wait_mem, resp_valid, resp_is_store, draining, outstanding[2:0]}
    function automatic logic [7:0] dut_vec();
        return {timeout_err, wait_mem, resp_valid, resp_is_store, draining, 3'(outstanding)};
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got {to,wt,rv,rs,dr,out}=%b required %b", nm, act, exp);
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d required %0d", nm, act, exp);
    endtask

    task automatic step(input logic iss, st, ok, fl);
        @(negedge clk);
        mem_issued = iss; mem_is_store = st; data_ok = ok; flush = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] expv(input logic wt, rv, rs, dr, input int out);
        return {1'b0, wt, rv, rs, dr, 3'(out)};
    endfunction

    initial begin
        //   iss st ok fl   wt rv rs dr out  name
        // 1: single load, response 3 cycles later
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, "t1_issue_load");
        add(0, 0, 0, 0,   0, 0, 0, 0, 1, "t1_wait_a");
        add(0, 0, 0, 0,   0, 0, 0, 0, 1, "t1_wait_b");
        add(0, 0, 1, 0,   0, 1, 0, 0, 0, "t1_resp_load");
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, "t1_idle");
        // 2: store then load fill the window; third issue dropped
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, "t2_issue_store");
        add(1, 0, 0, 0,   1, 0, 0, 0, 2, "t2_issue_load_full");
        add(1, 1, 0, 0,   1, 0, 0, 0, 2, "t2_third_dropped");
        add(0, 0, 1, 0,   0, 1, 1, 0, 1, "t2_resp_store");
        add(0, 0, 1, 0,   0, 1, 0, 0, 0, "t2_resp_load");
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, "t2_idle");
        // 3: issue and response in the same cycle keep the count, order preserved
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, "t3_issue_store");
        add(1, 0, 1, 0,   0, 1, 1, 0, 1, "t3_issue_and_pop");
        add(0, 0, 1, 0,   0, 1, 0, 0, 0, "t3_pop_load");
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, "t3_idle");
        // 4: flush with two in flight drains silently
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, "t4_issue_a");
        add(1, 1, 0, 0,   1, 0, 0, 0, 2, "t4_issue_b");
        add(0, 0, 0, 1,   1, 0, 0, 1, 2, "t4_flush_drain");
        add(0, 0, 1, 0,   1, 0, 0, 1, 1, "t4_drain_pop1");
        add(0, 0, 1, 0,   0, 0, 0, 0, 0, "t4_drain_pop2");
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, "t4_idle");
        // 5: flush + issue + response at count 1
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, "t5_issue");
        add(1, 0, 1, 1,   0, 0, 0, 0, 0, "t5_flush_all");
        add(0, 0, 0, 0,   0, 0, 0, 0, 0, "t5_idle");
        // boundaries
        add(0, 0, 1, 0,   0, 0, 0, 0, 0, "ok_at_zero_ignored");
        add(0, 0, 0, 1,   0, 0, 0, 0, 0, "flush_in_idle");
        add(1, 1, 0, 1,   0, 0, 0, 0, 0, "issue_with_flush_idle");
        add(1, 1, 0, 0,   0, 0, 0, 0, 1, "b_issue_store");
        add(0, 0, 0, 1,   1, 0, 0, 1, 1, "b_flush_cnt1");
        add(1, 0, 0, 0,   1, 0, 0, 1, 1, "b_issue_in_drain");
        add(0, 0, 0, 1,   1, 0, 0, 1, 1, "b_flush_in_drain");
        add(0, 0, 1, 1,   0, 0, 0, 0, 0, "b_pop_flush_drain");
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, "c_issue_a");
        add(1, 1, 0, 0,   1, 0, 0, 0, 2, "c_issue_b");
        add(0, 0, 1, 1,   1, 0, 0, 1, 1, "c_flush_with_pop");
        add(0, 0, 1, 0,   0, 0, 0, 0, 0, "c_last_pop");
        add(1, 0, 0, 0,   0, 0, 0, 0, 1, "d_issue_load");
        add(0, 0, 1, 0,   0, 1, 0, 0, 0, "d_resp_load");

        reset = 1'b1;
        mem_issued = 0; mem_is_store = 0; data_ok = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_held", dut_vec(), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("after_reset", dut_vec(), 8'h00);

        foreach (vq[i]) begin
            step(vq[i].iss, vq[i].st, vq[i].ok, vq[i].fl);
            check(vq[i].name, dut_vec(), expv(vq[i].wt, vq[i].rv, vq[i].rs, vq[i].dr, vq[i].out));
        end

        // Async reset in mid-operation; pointers must restart at slot 0.
        step(1, 1, 0, 0);
        check("r_issue_store", dut_vec(), expv(0, 0, 0, 0, 1));
        step(1, 1, 0, 0);
        check("r_issue_store2", dut_vec(), expv(1, 0, 0, 0, 2));
        @(negedge clk);
        mem_issued = 0; mem_is_store = 0;
        #2 reset = 1'b1;
        #1;
        check("r_async_clear", dut_vec(), 8'h00);
        @(negedge clk);
        reset = 1'b0;
        step(0, 0, 1, 0);
        check("r_late_resp_ignored", dut_vec(), 8'h00);
        step(1, 0, 0, 0);
        check("r_issue_load", dut_vec(), expv(0, 0, 0, 0, 1));
        step(0, 0, 1, 0);
        check("r_resp_load", dut_vec(), expv(0, 1, 0, 0, 0));
        step(0, 0, 0, 0);
        check("r_idle", dut_vec(), 8'h00);

`ifdef MEM_CTRL_TIMEOUT_EN
        begin
            int fired_at = -1;
            step(1, 0, 0, 0);
            check("wd_issue", dut_vec(), expv(0, 0, 0, 0, 1));
            for (int k = 1; k <= 300; k++) begin
                step(0, 0, 0, 0);
                if (timeout_err === 1'b1) begin
                    fired_at = k;
                    break;
                end
            end
            check_int("wd_fire_cycle", fired_at, 255);
            check("wd_state_at_fire", dut_vec(), 8'h80);
            step(0, 0, 0, 0);
            check("wd_after_pulse", dut_vec(), 8'h00);
        end
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
